video_timing_analyser: RTL and testbench

VIDEO_TIMING_ANALYSER -- requirements
Module: video_timing_analyser

---
 rtl/video_timing_analyser.sv | 247 ++++++++++++++++++++++++
 tb/tb_video_timing_analyser.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_analyser.sv
// video_timing_analyser
//   Measures the timing of an incoming video stream from its syncs and blanking
//   signals. It reports line and frame totals, active sizes, sync pulse lengths
//   and sync polarities. It raises a lock flag once consecutive frames agree.
//
// Ports
//   clk        : single clock, all logic on the rising edge
//   reset_n    : asynchronous active-low reset
//   pixel_stb  : pixel enable; inputs are sampled only when high
//   hsync_n    : horizontal sync, either polarity
//   vsync_n    : vertical sync, either polarity
//   hblank_n   : horizontal blanking, high = active video
//   vblank_n   : vertical blanking, high = active video
//   htotal     : last pixel index of a line (pixels - 1)
//   hactive    : active pixels per line
//   hsync_len  : pixels in the horizontal sync pulse
//   hpolarity  : level of the horizontal sync pulse
//   vtotal     : last line index of a frame (lines - 1)
//   vactive    : active lines per frame
//   vsync_len  : lines in the vertical sync pulse
//   vpolarity  : level of the vertical sync pulse
//   meas_stb   : one-clk pulse when the outputs are refreshed
//   locked     : stable timing detected
//   no_signal  : a counter saturated without seeing a line or frame start
//
// state   | meaning
// SEARCH  | waiting for the first frame start; no results are published
// MEASURE | publishing results and counting consecutive matching frames
// LOCKED  | enough consecutive frames have matched; locked is high
module video_timing_analyser #(
  parameter int hFramingBits = 12,
  parameter int vFramingBits = 12,
  parameter int stableFrames = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    pixel_stb,
  input  logic                    hsync_n,
  input  logic                    vsync_n,
  input  logic                    hblank_n,
  input  logic                    vblank_n,
  output logic [hFramingBits-1:0] htotal,
  output logic [hFramingBits-1:0] hactive,
  output logic [hFramingBits-1:0] hsync_len,
  output logic                    hpolarity,
  output logic [vFramingBits-1:0] vtotal,
  output logic [vFramingBits-1:0] vactive,
  output logic [vFramingBits-1:0] vsync_len,
  output logic                    vpolarity,
  output logic                    meas_stb,
  output logic                    locked,
  output logic                    no_signal
);

  localparam int H  = hFramingBits;
  localparam int V  = vFramingBits;
  localparam int CW = $clog2(stableFrames + 1);
  localparam logic [H-1:0] H_MAX = {H{1'b1}};
  localparam logic [H-1:0] H_ONE = H'(1);
  localparam logic [V-1:0] V_MAX = {V{1'b1}};
  localparam logic [V-1:0] V_ONE = V'(1);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   match_cnt, match_cnt_nxt;

  logic            hblank_q, vblank_q;
  logic [H-1:0]    hcnt, hlow, hhigh, hact;
  logic [H-1:0]    line_len_q, line_low_q, line_high_q, line_act_q;
  logic [V-1:0]    vcnt, vlow, vhigh, vact;

  logic            line_start, frame_start, timeout, update, match;
  logic [H-1:0]    cur_len, cur_low, cur_high, cur_act;
  logic [H-1:0]    new_htotal, new_hsync_len;
  logic [V-1:0]    new_vtotal, new_vsync_len;
  logic            new_hpol, new_vpol, h_low_wins, v_low_wins;

  function automatic logic [H-1:0] hinc(input logic [H-1:0] x);
    return (x == H_MAX) ? x : x + H_ONE;
  endfunction

  function automatic logic [V-1:0] vinc(input logic [V-1:0] x);
    return (x == V_MAX) ? x : x + V_ONE;
  endfunction

  assign line_start  = pixel_stb & hblank_n & ~hblank_q;
  assign frame_start = pixel_stb & vblank_n & ~vblank_q;

  // A line start never times out on hcnt because it restarts the count; a
  // frame start likewise restarts the line counter.
  assign timeout = pixel_stb &
                   ((~line_start & (hcnt == H_MAX)) |
                    (line_start & ~frame_start & (vcnt == V_MAX)));

  // The line that just ended is the last complete line when this sample also
  // starts a line; otherwise the last captured line is used.
  assign cur_len  = line_start ? hcnt  : line_len_q;
  assign cur_low  = line_start ? hlow  : line_low_q;
  assign cur_high = line_start ? hhigh : line_high_q;
  assign cur_act  = line_start ? hact  : line_act_q;

  assign h_low_wins    = cur_low < cur_high;
  assign new_htotal    = cur_len - H_ONE;
  assign new_hsync_len = h_low_wins ? cur_low : cur_high;
  assign new_hpol      = ~h_low_wins;

  assign v_low_wins    = vlow < vhigh;
  assign new_vtotal    = vcnt - V_ONE;
  assign new_vsync_len = v_low_wins ? vlow : vhigh;
  assign new_vpol      = ~v_low_wins;

  assign match = (new_htotal == htotal) && (cur_act == hactive) &&
                 (new_vtotal == vtotal) && (vact == vactive);

  assign update = frame_start & ~timeout & (state != SEARCH);
  assign locked = (state == LOCKED);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SEARCH;
      match_cnt <= '0;
    end else begin
      state     <= state_nxt;
      match_cnt <= match_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    match_cnt_nxt = match_cnt;
    if (timeout) begin
      state_nxt     = SEARCH;
      match_cnt_nxt = '0;
    end else if (frame_start) begin
      case (state)
        SEARCH: begin
          state_nxt     = MEASURE;
          match_cnt_nxt = '0;
        end
        MEASURE: begin
          if (match) begin
            if (int'(match_cnt) + 1 >= stableFrames - 1) begin
              state_nxt     = LOCKED;
              match_cnt_nxt = '0;
            end else begin
              match_cnt_nxt = CW'(int'(match_cnt) + 1);
            end
          end else begin
            match_cnt_nxt = '0;
          end
        end
        LOCKED: begin
          if (!match) begin
            state_nxt     = MEASURE;
            match_cnt_nxt = '0;
          end
        end
        default: begin
          state_nxt     = SEARCH;
          match_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hblank_q    <= 1'b1;
      vblank_q    <= 1'b1;
      hcnt        <= '0;
      hlow        <= '0;
      hhigh       <= '0;
      hact        <= '0;
      line_len_q  <= '0;
      line_low_q  <= '0;
      line_high_q <= '0;
      line_act_q  <= '0;
      vcnt        <= '0;
      vlow        <= '0;
      vhigh       <= '0;
      vact        <= '0;
      htotal      <= '0;
      hactive     <= '0;
      hsync_len   <= '0;
      hpolarity   <= 1'b0;
      vtotal      <= '0;
      vactive     <= '0;
      vsync_len   <= '0;
      vpolarity   <= 1'b0;
      meas_stb    <= 1'b0;
      no_signal   <= 1'b1;
    end else begin
      meas_stb <= 1'b0;
      if (pixel_stb) begin
        hblank_q <= hblank_n;
        vblank_q <= vblank_n;
        // The line-start sample is the first pixel of the new line.
        if (line_start) begin
          line_len_q  <= hcnt;
          line_low_q  <= hlow;
          line_high_q <= hhigh;
          line_act_q  <= hact;
          hcnt        <= H_ONE;
          hlow        <= hsync_n ? '0 : H_ONE;
          hhigh       <= hsync_n ? H_ONE : '0;
          hact        <= H_ONE;
        end else begin
          hcnt <= hinc(hcnt);
          if (!hsync_n) hlow  <= hinc(hlow);
          else          hhigh <= hinc(hhigh);
          if (hblank_n) hact <= hinc(hact);
        end
        // A line starting on the frame-start sample is line 1 of the new frame.
        if (frame_start) begin
          vcnt  <= line_start ? V_ONE : '0;
          vlow  <= (line_start && !vsync_n) ? V_ONE : '0;
          vhigh <= (line_start && vsync_n) ? V_ONE : '0;
          vact  <= line_start ? V_ONE : '0;
        end else if (line_start) begin
          vcnt <= vinc(vcnt);
          if (!vsync_n) vlow  <= vinc(vlow);
          else          vhigh <= vinc(vhigh);
          if (vblank_n) vact <= vinc(vact);
        end
      end
      if (timeout)          no_signal <= 1'b1;
      else if (frame_start) no_signal <= 1'b0;
      if (update) begin
        htotal    <= new_htotal;
        hactive   <= cur_act;
        hsync_len <= new_hsync_len;
        hpolarity <= new_hpol;
        vtotal    <= new_vtotal;
        vactive   <= vact;
        vsync_len <= new_vsync_len;
        vpolarity <= new_vpol;
        meas_stb  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_analyser.sv
// Directed bench for video_timing_analyser using a reduced 40x20 video mode:
// 32 active pixels, 4-pixel hsync low at x=34..37, 12 active lines and
// 2-line vsync low at y=14..15. Expected results: htotal=39, hactive=32,
// hsync_len=4, vtotal=19, vactive=12, vsync_len=2.
module tb_video_timing_analyser;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pixel_stb;
  logic        hsync_n, vsync_n, hblank_n, vblank_n;
  logic [11:0] htotal, hactive, hsync_len, vtotal, vactive, vsync_len;
  logic        hpolarity, vpolarity, meas_stb, locked, no_signal;

  int tests = 0;
  int fails = 0;
  int stb_period = 4;
  int meas_seen = 0;
  int mbase;

  logic        s_meas, s_locked, s_nosig, s_hp, s_vp;
  logic [11:0] s_ht, s_ha, s_hl, s_vt, s_va, s_vl;
  logic        fs_meas, fs_locked, fs_nosig, fs_hp, fs_vp;
  logic [11:0] fs_ht, fs_ha, fs_hl, fs_vt, fs_va, fs_vl;

  video_timing_analyser dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pixel_stb (pixel_stb),
    .hsync_n   (hsync_n),
    .vsync_n   (vsync_n),
    .hblank_n  (hblank_n),
    .vblank_n  (vblank_n),
    .htotal    (htotal),
    .hactive   (hactive),
    .hsync_len (hsync_len),
    .hpolarity (hpolarity),
    .vtotal    (vtotal),
    .vactive   (vactive),
    .vsync_len (vsync_len),
    .vpolarity (vpolarity),
    .meas_stb  (meas_stb),
    .locked    (locked),
    .no_signal (no_signal)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (meas_stb === 1'b1) meas_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One sample: strobe for one clk, capture outputs just after that edge,
  // then idle for the rest of the strobe period.
  task automatic do_sample();
    pixel_stb = 1'b1;
    @(posedge clk); #1;
    pixel_stb = 1'b0;
    s_meas = meas_stb; s_locked = locked; s_nosig = no_signal;
    s_ht = htotal; s_ha = hactive; s_hl = hsync_len; s_hp = hpolarity;
    s_vt = vtotal; s_va = vactive; s_vl = vsync_len; s_vp = vpolarity;
    if (stb_period > 1) begin
      repeat (stb_period - 1) @(posedge clk);
      #1;
    end
  endtask

  task automatic px(input int x, input int y, input int ha, input bit inv);
    hblank_n = (x < ha);
    vblank_n = (y < 12);
    hsync_n  = ((x >= 34 && x < 38) ? 1'b0 : 1'b1) ^ inv;
    vsync_n  = ((y >= 14 && y < 16) ? 1'b0 : 1'b1) ^ inv;
    do_sample();
    if (x == 0 && y == 0) begin
      fs_meas = s_meas; fs_locked = s_locked; fs_nosig = s_nosig;
      fs_ht = s_ht; fs_ha = s_ha; fs_hl = s_hl; fs_hp = s_hp;
      fs_vt = s_vt; fs_va = s_va; fs_vl = s_vl; fs_vp = s_vp;
    end
  endtask

  task automatic send_lines(input int y0, input int y1, input int ha, input bit inv);
    for (int y = y0; y <= y1; y++)
      for (int x = 0; x < 40; x++)
        px(x, y, ha, inv);
  endtask

  task automatic check_fs(input string tag, input int ht, input int ha, input int hl,
                          input int hp, input int vt, input int va, input int vl, input int vp);
    check({tag, ".htotal"},    32'(fs_ht), 32'(ht));
    check({tag, ".hactive"},   32'(fs_ha), 32'(ha));
    check({tag, ".hsync_len"}, 32'(fs_hl), 32'(hl));
    check({tag, ".hpolarity"}, 32'(fs_hp), 32'(hp));
    check({tag, ".vtotal"},    32'(fs_vt), 32'(vt));
    check({tag, ".vactive"},   32'(fs_va), 32'(va));
    check({tag, ".vsync_len"}, 32'(fs_vl), 32'(vl));
    check({tag, ".vpolarity"}, 32'(fs_vp), 32'(vp));
  endtask

  initial begin
    reset_n = 1'b0; pixel_stb = 1'b0;
    hsync_n = 1'b1; vsync_n = 1'b1; hblank_n = 1'b0; vblank_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.htotal",    32'(htotal), 0);
    check("rst.hactive",   32'(hactive), 0);
    check("rst.hsync_len", 32'(hsync_len), 0);
    check("rst.hpolarity", 32'(hpolarity), 0);
    check("rst.vtotal",    32'(vtotal), 0);
    check("rst.vactive",   32'(vactive), 0);
    check("rst.vsync_len", 32'(vsync_len), 0);
    check("rst.vpolarity", 32'(vpolarity), 0);
    check("rst.meas_stb",  32'(meas_stb), 0);
    check("rst.locked",    32'(locked), 0);
    check("rst.no_signal", 32'(no_signal), 1);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Strobe every 4 clk: join mid-frame, then three full frames.
    send_lines(15, 19, 32, 1'b0);
    mbase = meas_seen;
    send_lines(0, 19, 32, 1'b0);
    check("fs1.meas_stb",  32'(fs_meas), 0);
    check("fs1.no_signal", 32'(fs_nosig), 0);
    check("fs1.pulses",    32'(meas_seen - mbase), 0);
    send_lines(0, 19, 32, 1'b0);
    check_fs("fs2", 39, 32, 4, 0, 19, 12, 2, 0);
    check("fs2.meas_stb",  32'(fs_meas), 1);
    check("fs2.locked",    32'(fs_locked), 0);
    check("fs2.pulses",    32'(meas_seen - mbase), 1);
    send_lines(0, 19, 32, 1'b0);
    check("fs3.meas_stb",  32'(fs_meas), 1);
    check("fs3.locked",    32'(fs_locked), 1);

    // Remaining phases strobe every clk.
    stb_period = 1;
    send_lines(0, 19, 32, 1'b1);
    check("fs4.locked", 32'(fs_locked), 1);
    send_lines(0, 19, 32, 1'b1);
    check_fs("inv", 39, 32, 4, 1, 19, 12, 2, 1);
    check("inv.locked", 32'(fs_locked), 1);
    send_lines(0, 19, 36, 1'b0);
    check("fs6.locked", 32'(fs_locked), 1);
    send_lines(0, 19, 32, 1'b0);
    check("wide.hactive",  32'(fs_ha), 36);
    check("wide.meas_stb", 32'(fs_meas), 1);
    check("wide.locked",   32'(fs_locked), 0);
    send_lines(0, 19, 32, 1'b0);
    check("back1.hactive", 32'(fs_ha), 32);
    check("back1.locked",  32'(fs_locked), 0);
    send_lines(0, 19, 32, 1'b0);
    check("back2.locked",  32'(fs_locked), 1);
    check("back2.hsync",   32'(fs_hp), 0);

    // Timeout: hblank_n stuck high; the 4096th sample saturates hcnt.
    mbase = meas_seen;
    hblank_n = 1'b1; vblank_n = 1'b0; hsync_n = 1'b1; vsync_n = 1'b1;
    repeat (4095) do_sample();
    check("to.edge_nosig",  32'(no_signal), 0);
    check("to.edge_locked", 32'(locked), 1);
    do_sample();
    check("to.no_signal", 32'(no_signal), 1);
    check("to.locked",    32'(locked), 0);
    check("to.htotal",    32'(htotal), 39);
    check("to.hactive",   32'(hactive), 32);
    check("to.vtotal",    32'(vtotal), 19);
    check("to.pulses",    32'(meas_seen - mbase), 0);
    hblank_n = 1'b0;
    do_sample();
    send_lines(0, 19, 32, 1'b0);
    check("rec1.no_signal", 32'(fs_nosig), 0);
    check("rec1.meas_stb",  32'(fs_meas), 0);
    check("rec1.locked",    32'(fs_locked), 0);
    send_lines(0, 19, 32, 1'b0);
    check("rec2.meas_stb",  32'(fs_meas), 1);
    check("rec2.htotal",    32'(fs_ht), 39);
    check("rec2.vtotal",    32'(fs_vt), 19);

    // One-clk reset pulse in the middle of line 3.
    send_lines(0, 2, 32, 1'b0);
    for (int x = 0; x < 10; x++) px(x, 3, 32, 1'b0);
    reset_n = 1'b0;
    #1;
    check("mrst.htotal",    32'(htotal), 0);
    check("mrst.vtotal",    32'(vtotal), 0);
    check("mrst.hactive",   32'(hactive), 0);
    check("mrst.no_signal", 32'(no_signal), 1);
    check("mrst.locked",    32'(locked), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int x = 10; x < 40; x++) px(x, 3, 32, 1'b0);
    send_lines(4, 19, 32, 1'b0);
    mbase = meas_seen;
    send_lines(0, 19, 32, 1'b0);
    check("mrst1.meas_stb",  32'(fs_meas), 0);
    check("mrst1.htotal",    32'(fs_ht), 0);
    check("mrst1.no_signal", 32'(fs_nosig), 0);
    check("mrst1.pulses",    32'(meas_seen - mbase), 0);
    send_lines(0, 19, 32, 1'b0);
    check_fs("mrst2", 39, 32, 4, 0, 19, 12, 2, 0);
    check("mrst2.meas_stb", 32'(fs_meas), 1);
    check("mrst2.locked",   32'(fs_locked), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
